// File: rtl/sdram_word_bridge.sv
// sdram_word_bridge: splits 32-bit CPU word accesses into two
// 16-bit SDRAM controller accesses, low half first.
module sdram_word_bridge #(
  parameter int SD_ADDR_W = 24,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  output logic [31:0]          mem_rdata,
  output logic                 mem_ready,
  output logic                 mem_err,
  output logic                 req_valid,
  input  logic                 req_ready,
  output logic                 req_we,
  output logic [SD_ADDR_W-1:0] req_addr,
  output logic [15:0]          req_wdata,
  input  logic                 rsp_valid,
  input  logic [15:0]          rsp_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_LO,
    S_RSP_LO,
    S_REQ_HI,
    S_RSP_HI,
    S_DONE
  } state_t;

  localparam int         WA_W    = SD_ADDR_W - 1;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t                 r_state, w_state;
  logic [WA_W-1:0]        r_addr, w_addr;
  logic [31:0]            r_wdata, w_wdata;
  logic                   r_we, w_we;
  logic [15:0]            r_lo, w_lo;
  logic [7:0]             r_cnt, w_cnt;
  logic                   r_req_valid, w_req_valid;
  logic                   r_req_we, w_req_we;
  logic [SD_ADDR_W-1:0]   r_req_addr, w_req_addr;
  logic [15:0]            r_req_wdata, w_req_wdata;
  logic [31:0]            r_rdata, w_rdata;
  logic                   r_ready, w_ready;
  logic                   r_err, w_err;
  logic                   w_to;
  logic                   w_unused;

  // byte-lane and out-of-range address bits have no meaning here
  assign w_unused = ^{mem_addr[31:SD_ADDR_W+1], mem_addr[1:0]};

  assign w_to      = (r_cnt == TO_LAST);
  assign mem_rdata = r_rdata;
  assign mem_ready = r_ready;
  assign mem_err   = r_err;
  assign req_valid = r_req_valid;
  assign req_we    = r_req_we;
  assign req_addr  = r_req_addr;
  assign req_wdata = r_req_wdata;

  // next-state and next-register values for the whole bridge
  always_comb begin
    w_state     = r_state;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_we        = r_we;
    w_lo        = r_lo;
    w_cnt       = r_cnt;
    w_req_valid = r_req_valid;
    w_req_we    = r_req_we;
    w_req_addr  = r_req_addr;
    w_req_wdata = r_req_wdata;
    w_rdata     = r_rdata;
    w_ready     = 1'b0;
    w_err       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mem_write | mem_read) begin
          w_we        = mem_write;
          w_addr      = mem_addr[SD_ADDR_W:2];
          w_wdata     = mem_wdata;
          w_req_valid = 1'b1;
          w_req_we    = mem_write;
          w_req_addr  = {mem_addr[SD_ADDR_W:2], 1'b0};
          w_req_wdata = mem_wdata[15:0];
          w_state     = S_REQ_LO;
        end
      end
      S_REQ_LO: begin
        if (r_req_valid & req_ready) begin
          w_req_valid = 1'b0;
          w_cnt       = '0;
          w_state     = r_we ? S_REQ_HI : S_RSP_LO;
        end
      end
      S_RSP_LO: begin
        if (rsp_valid) begin
          w_lo    = rsp_rdata;
          w_state = S_REQ_HI;
        end else if (w_to) begin
          w_rdata = 32'hDEAD_BEEF;
          w_ready = 1'b1;
          w_err   = 1'b1;
          w_state = S_DONE;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_REQ_HI: begin
        if (!r_req_valid) begin
          w_req_valid = 1'b1;
          w_req_we    = r_we;
          w_req_addr  = {r_addr, 1'b1};
          w_req_wdata = r_wdata[31:16];
        end else if (req_ready) begin
          w_req_valid = 1'b0;
          w_cnt       = '0;
          if (r_we) begin
            w_ready = 1'b1;
            w_state = S_DONE;
          end else begin
            w_state = S_RSP_HI;
          end
        end
      end
      S_RSP_HI: begin
        if (rsp_valid) begin
          w_rdata = {rsp_rdata, r_lo};
          w_ready = 1'b1;
          w_state = S_DONE;
        end else if (w_to) begin
          w_rdata = 32'hDEAD_BEEF;
          w_ready = 1'b1;
          w_err   = 1'b1;
          w_state = S_DONE;
        end else begin
          w_cnt = r_cnt + 8'd1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // latched access, counter and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_lo        <= '0;
      r_cnt       <= '0;
      r_req_valid <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_rdata     <= '0;
      r_ready     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_we        <= w_we;
      r_lo        <= w_lo;
      r_cnt       <= w_cnt;
      r_req_valid <= w_req_valid;
      r_req_we    <= w_req_we;
      r_req_addr  <= w_req_addr;
      r_req_wdata <= w_req_wdata;
      r_rdata     <= w_rdata;
      r_ready     <= w_ready;
      r_err       <= w_err;
    end
  end

endmodule

// File: tb/tb_sdram_word_bridge.sv
// tb_sdram_word_bridge: scoreboard bench with a word-level memory
// model, a randomized halfword controller and a completion monitor.
module tb_sdram_word_bridge;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mem_err;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [23:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;

  sdram_word_bridge #(.SD_ADDR_W(24), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
  );

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [15:0] wdata;
    int          stall;
    int          dly;
    bit          drop;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          start;
    bit          tmo;
  } sb_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } rsp_t;

  req_t exp_req[$];
  sb_t  sb[$];
  rsp_t pend[$];

  logic [15:0] dev_mem[logic [23:0]];
  logic [31:0] ref_mem[logic [22:0]];
  logic [31:0] model_last;
  logic [22:0] pool[6];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wcnt = 0;
  int lo_acc = 0;
  int rsp_cnt = 0;
  int snap_seq = 0;
  int snap_seen = 0;
  int fail_seq = 0;
  int fail_seen = 0;
  bit end_req = 0;
  bit end_done = 0;
  logic snap_valid;
  logic snap_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // controller model, reset checks and completion monitor
  always @(negedge clk) begin
    req_t        e;
    sb_t         s;
    rsp_t        r;
    logic [15:0] d;
    if (snap_seq != snap_seen) begin
      chk("async_rst_req_valid", {31'b0, snap_valid}, 32'h0);
      chk("async_rst_mem_ready", {31'b0, snap_ready}, 32'h0);
      snap_seen = snap_seq;
    end
    if (fail_seq != fail_seen) begin
      chk("wait_timeout", 32'(fail_seq - fail_seen), 32'h0);
      fail_seen = fail_seq;
    end
    if (!reset) begin
      chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
      chk("rst_mem_ready", {31'b0, mem_ready}, 32'h0);
      chk("rst_mem_err", {31'b0, mem_err}, 32'h0);
      chk("rst_mem_rdata", mem_rdata, 32'h0);
      exp_req.delete();
      sb.delete();
      pend.delete();
      wcnt = 0;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      rsp_rdata = 16'h0;
    end else begin
      rsp_valid = 1'b0;
      rsp_rdata = 16'($urandom);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        rsp_valid = 1'b1;
        rsp_rdata = r.data;
        rsp_cnt++;
      end
      req_ready = 1'b0;
      if (req_valid) begin
        if (exp_req.size() == 0) begin
          chk("spurious_req", {31'b0, req_valid}, 32'h0);
        end else begin
          e = exp_req[0];
          chk("req_we", {31'b0, req_we}, {31'b0, e.we});
          chk("req_addr", {8'h0, req_addr}, {8'h0, e.addr});
          if (e.we) chk("req_wdata", {16'h0, req_wdata}, {16'h0, e.wdata});
          if (wcnt >= e.stall) begin
            req_ready = 1'b1;
            wcnt = 0;
            void'(exp_req.pop_front());
            if (e.we) begin
              dev_mem[req_addr] = req_wdata;
            end else begin
              if (!req_addr[0]) lo_acc = cyc + 1;
              if (!e.drop) begin
                d = dev_mem.exists(req_addr) ? dev_mem[req_addr] : 16'h0;
                r.due = cyc + e.dly;
                r.data = d;
                pend.push_back(r);
              end
            end
          end else begin
            wcnt++;
          end
        end
      end
      if (mem_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_ready", {31'b0, mem_ready}, 32'h0);
        end else begin
          s = sb.pop_front();
          chk("mem_rdata", mem_rdata, s.rdata);
          chk("mem_err", {31'b0, mem_err}, {31'b0, s.err});
          if (s.lat >= 0)
            chk("latency", 32'(cyc - s.start), 32'(s.lat));
          if (s.tmo)
            chk("timeout_cycle", 32'(cyc), 32'(lo_acc + 64));
        end
      end
    end
    if (end_req && !end_done) begin
      chk("sb_left", 32'(sb.size()), 32'h0);
      chk("req_left", 32'(exp_req.size()), 32'h0);
      end_done = 1'b1;
    end
  end

  task automatic recover();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    model_last = 32'h0;
  endtask

  task automatic do_access(input bit w, input bit rd,
                           input logic [31:0] a, input logic [31:0] dt,
                           input int st, input int dl, input bit drop,
                           input int lat);
    req_t        q;
    sb_t         s;
    logic [22:0] wi;
    bit          got;
    wi = a[24:2];
    @(negedge clk);
    q.we    = w;
    q.addr  = {wi, 1'b0};
    q.wdata = dt[15:0];
    q.stall = (st < 0) ? int'($urandom_range(0, 3)) : st;
    q.dly   = (dl <= 0) ? int'($urandom_range(1, 4)) : dl;
    q.drop  = drop && !w;
    exp_req.push_back(q);
    s.lat   = lat;
    s.start = cyc;
    s.tmo   = 1'b0;
    s.err   = 1'b0;
    if (w || !q.drop) begin
      q.addr  = {wi, 1'b1};
      q.wdata = dt[31:16];
      q.stall = (st < 0) ? int'($urandom_range(0, 3)) : st;
      q.dly   = (dl <= 0) ? int'($urandom_range(1, 4)) : dl;
      exp_req.push_back(q);
    end
    if (w) begin
      ref_mem[wi] = dt;
      s.rdata = model_last;
    end else if (q.drop) begin
      s.rdata = 32'hDEAD_BEEF;
      s.err   = 1'b1;
      s.tmo   = 1'b1;
    end else begin
      s.rdata = ref_mem.exists(wi) ? ref_mem[wi] : 32'h0;
    end
    if (!w) model_last = s.rdata;
    sb.push_back(s);
    mem_addr  = a;
    mem_wdata = dt;
    mem_write = w;
    mem_read  = rd;
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (mem_ready) begin
        got = 1'b1;
        break;
      end
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = $urandom;
    mem_wdata = $urandom;
    if (!got) begin
      fail_seq++;
      recover();
    end
  endtask

  initial begin
    req_t q;
    bit   got;
    reset      = 1'b0;
    mem_read   = 1'b1;
    mem_write  = 1'b0;
    mem_addr   = 32'h4;
    mem_wdata  = 32'h0;
    model_last = 32'h0;
    pool[0] = 23'h000000;
    pool[1] = 23'h000001;
    pool[2] = 23'h000002;
    pool[3] = 23'h7FFFFF;
    pool[4] = 23'h123456;
    pool[5] = 23'h000100;
    repeat (5) @(negedge clk);
    mem_read = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;

    do_access(1, 0, 32'h0000_0004, 32'hCAFE_ABCD, 0, 1, 0, 4);
    do_access(0, 1, 32'h0000_0004, 32'h0, 0, 1, 0, 6);
    do_access(0, 1, 32'h0000_0004, 32'h1234_5678, 2, 3, 0, -1);
    do_access(0, 1, 32'h0000_0100, 32'h0, 0, 1, 1, -1);
    do_access(1, 0, 32'h0000_0008, 32'h1111_2222, 1, 1, 0, -1);
    do_access(1, 1, 32'h01FF_FFFC, 32'h5A5A_1234, 0, 1, 0, 4);
    do_access(0, 1, 32'hFFFF_FFFF, 32'h0, 0, 1, 0, 6);

    @(negedge clk);
    q.we = 1'b0; q.addr = 24'h000004; q.wdata = 16'h0;
    q.stall = 0; q.dly = 1; q.drop = 1'b0;
    exp_req.push_back(q);
    q.addr = 24'h000005; q.stall = 5;
    exp_req.push_back(q);
    mem_addr = 32'h0000_0008;
    mem_read = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_cnt > 0 && req_valid && req_addr[0]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail_seq++;
    #2 reset = 1'b0;
    mem_read = 1'b0;
    #1 snap_valid = req_valid;
    snap_ready = mem_ready;
    snap_seq++;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    model_last = 32'h0;
    do_access(1, 0, 32'h0000_0010, 32'h0BAD_F00D, 0, 1, 0, 4);
    do_access(0, 1, 32'h0000_0008, 32'h0, 0, 1, 0, 6);

    for (int i = 0; i < 40; i++) begin
      int          op;
      int          k;
      bit          w;
      bit          rd;
      bit          drop;
      logic [31:0] a;
      op = $urandom_range(0, 9);
      k  = $urandom_range(0, 5);
      a  = {7'($urandom), pool[k], 2'($urandom)};
      w  = (op < 4) || (op >= 8);
      rd = (op >= 4);
      drop = !w && ($urandom_range(0, 7) == 0);
      do_access(w, rd, a, $urandom, -1, -1, drop, -1);
    end

    repeat (3) @(negedge clk);
    end_req = 1'b1;
    for (int k = 0; k < 10 && !end_done; k++) @(negedge clk);
    if (!end_done) begin
      n_bad++;
      $display("FAIL end_handshake: got 0 want 1");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
